sram_port_arbiter: RTL

- Parametrised successor to the single-SRAM testbench/corelet select mux.
- Arbitrates NCH requesters onto one single-port, active-low-strobe SRAM macro (e.g. sram_32b_w128), using fixed-priority or round-robin arbitration.
- Registers the SRAM control/address/data, and returns read data tagged to the issuing channel with fixed latency.
- Sits between core-level requesters (testbench preload port, corelet L0/ofifo loaders) and the SRAM instance.

---
 rtl/sram_port_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Purpose: shares one single-port SRAM macro with active-low strobes among NCH
// requesters. One request is granted per cycle, using fixed priority or
// round-robin. The SRAM control, address and write data are registered. Read
// data returns to the issuing channel a fixed two cycles after the grant.
//
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   prio_override  channel 0 wins whenever it is valid
//   req_valid      per-channel request valid                [NCH]
//   req_ready      per-channel grant, one-hot or zero       [NCH]
//   req_write      1 = write, 0 = read                      [NCH]
//   req_lock       keep the grant on the last issuer        [NCH]
//   req_addr       flattened addresses, ch i at [i*aw +: aw]
//   req_data       flattened write data, ch i at [i*bw +: bw]
//   rd_valid       one-hot read-return valid                [NCH]
//   rd_data        read data shared by all channels (passthrough of sram_Q)
//   sram_CEN/WEN   active-low chip / write enable
//   sram_A, sram_D SRAM address and write data
//   sram_Q         SRAM read data, one cycle after the SRAM samples a read
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
   parameter int NCH = 2,
   parameter int bw  = 32,
   parameter int aw  = 7,
   parameter int RR  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              prio_override,
   input  logic [NCH-1:0]    req_valid,
   output logic [NCH-1:0]    req_ready,
   input  logic [NCH-1:0]    req_write,
   input  logic [NCH-1:0]    req_lock,
   input  logic [NCH*aw-1:0] req_addr,
   input  logic [NCH*bw-1:0] req_data,
   output logic [NCH-1:0]    rd_valid,
   output logic [bw-1:0]     rd_data,
   output logic              sram_CEN,
   output logic              sram_WEN,
   output logic [aw-1:0]     sram_A,
   output logic [bw-1:0]     sram_D,
   input  logic [bw-1:0]     sram_Q
);

   localparam int            PW       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [PW:0]   NCH_W    = (PW+1)'(NCH);
   localparam logic [PW-1:0] NCH_LAST = PW'(NCH - 1);

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_last;
   logic          r_lock_arm;
   logic          r_rd_vld_p1;
   logic [PW-1:0] r_rd_ch_p1;

   logic          w_issue;
   logic [PW-1:0] w_gnt;
   logic          w_lock_hold;
   logic [PW:0]   w_cand;
   logic [aw-1:0] w_addr;
   logic [bw-1:0] w_wdata;

   // r_lock_arm keeps a stale r_last (reset value 0) from acting as a lock
   // owner before any channel has actually issued.
   always_comb begin
      w_lock_hold = r_lock_arm && req_lock[r_last] && req_valid[r_last];
   end

   // Arbitration. The scan runs from the farthest candidate back to the
   // nearest so the last hit, i.e. the nearest valid channel, wins.
   always_comb begin
      w_issue = 1'b0;
      w_gnt   = '0;
      w_cand  = '0;
      if (prio_override && req_valid[0]) begin
         w_issue = 1'b1;
         w_gnt   = '0;
      end else if (w_lock_hold) begin
         w_issue = 1'b1;
         w_gnt   = r_last;
      end else begin
         for (int k = NCH - 1; k >= 0; k--) begin
            if (RR != 0) begin
               w_cand = {1'b0, r_ptr} + (PW+1)'(k);
               if (w_cand >= NCH_W) begin
                  w_cand = w_cand - NCH_W;
               end
            end else begin
               w_cand = (PW+1)'(k);
            end
            if (req_valid[w_cand[PW-1:0]]) begin
               w_issue = 1'b1;
               w_gnt   = w_cand[PW-1:0];
            end
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (w_issue) begin
         req_ready[w_gnt] = 1'b1;
      end
   end

   always_comb begin
      w_addr  = '0;
      w_wdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_gnt == PW'(i)) begin
            w_addr  = req_addr[i*aw +: aw];
            w_wdata = req_data[i*bw +: bw];
         end
      end
   end

   // ---- stage p1: SRAM drive and read tag; stage p2: rd_valid ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr       <= '0;
         r_last      <= '0;
         r_lock_arm  <= 1'b0;
         sram_CEN    <= 1'b1;
         sram_WEN    <= 1'b1;
         sram_A      <= '0;
         sram_D      <= '0;
         r_rd_vld_p1 <= 1'b0;
         rd_valid    <= '0;
      end else begin
         sram_CEN    <= ~w_issue;
         sram_WEN    <= ~(w_issue & req_write[w_gnt]);
         r_rd_vld_p1 <= w_issue & ~req_write[w_gnt];
         rd_valid    <= '0;
         if (r_rd_vld_p1) begin
            rd_valid[r_rd_ch_p1] <= 1'b1;
         end
         if (w_issue) begin
            r_ptr      <= (w_gnt == NCH_LAST) ? '0 : w_gnt + PW'(1);
            r_last     <= w_gnt;
            r_lock_arm <= 1'b1;
            sram_A     <= w_addr;
            if (req_write[w_gnt]) begin
               sram_D <= w_wdata;
            end
         end
      end
   end

   // Channel tag needs no reset: it is only consumed when r_rd_vld_p1 is set.
   always_ff @(posedge clk) begin
      r_rd_ch_p1 <= w_gnt;
   end

   assign rd_data = sram_Q;

endmodule
